// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Scancode prefixes, frame FSM states and the buffered event layout.
package ps2_keyboard_rx_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    localparam int EVENT_W = $bits(ps2_event_t);

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data,
                                           input logic       par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through event FIFO with occupancy count.
// Head entry reads as zero while empty; pointers wrap modulo DEPTH.
module ps2_event_fifo
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int WIDTH = EVENT_W,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin filtering, 11-bit frame deframing, odd parity,
// E0/F0 prefix decoding into make/break events, event FIFO and byte history.
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int HIST_BYTES     = 3,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            PS2_CLK,
    input  logic                            PS2_DAT,
    input  logic                            rd_en,
    input  logic                            clr_flags,
    output logic                            ev_valid,
    output logic [7:0]                      ev_code,
    output logic                            ev_ext,
    output logic                            ev_break,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
    output logic [8*HIST_BYTES-1:0]         history,
    output logic                            overflow,
    output logic                            parity_err,
    output logic                            frame_err
);

    localparam int HW = 8 * HIST_BYTES;
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [FW-1:0] clk_cnt_q;
    logic [FW-1:0] dat_cnt_q;
    logic          clk_f_q;
    logic          dat_f_q;
    logic          clk_prev_q;
    logic          fall;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;

    logic          stop_sample;
    logic          par_ok;
    logic          frame_ok;
    logic          bad_par;
    logic          bad_stop;
    logic          timeout;

    logic [HW-1:0] hist_q;
    logic [HW+7:0] hist_shift;
    logic [HW-1:0] hist_d;
    logic          ext_q;
    logic          brk_q;
    logic          ev_push;
    ps2_event_t    push_ev;

    logic          ev_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [EVENT_W-1:0] head_raw;
    ps2_event_t    head;

    logic          overflow_q;
    logic          parity_err_q;
    logic          frame_err_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[0], PS2_DAT};
        end
    end

    // Filtered level flips only after FILTER_LEN consecutive opposite samples.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_cnt_q <= '0;
            clk_f_q   <= 1'b1;
        end else if (clk_sync_q[1] == clk_f_q) begin
            clk_cnt_q <= '0;
        end else if (clk_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_cnt_q <= '0;
            clk_f_q   <= clk_sync_q[1];
        end else begin
            clk_cnt_q <= clk_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            dat_cnt_q <= '0;
            dat_f_q   <= 1'b1;
        end else if (dat_sync_q[1] == dat_f_q) begin
            dat_cnt_q <= '0;
        end else if (dat_cnt_q == FW'(FILTER_LEN - 1)) begin
            dat_cnt_q <= '0;
            dat_f_q   <= dat_sync_q[1];
        end else begin
            dat_cnt_q <= dat_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            clk_prev_q <= 1'b1;
        end else begin
            clk_prev_q <= clk_f_q;
        end
    end

    assign fall = clk_prev_q && !clk_f_q;

    assign stop_sample = fall && (state_q == ST_STOP);
    assign par_ok      = odd_parity_ok(shreg_q, par_q);
    assign frame_ok    = stop_sample && par_ok && dat_f_q;
    assign bad_par     = stop_sample && !par_ok;
    assign bad_stop    = stop_sample && par_ok && !dat_f_q;
    assign timeout     = (state_q != ST_IDLE) && !fall
                         && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else if (timeout) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            if ((state_q == ST_IDLE) || fall) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
            if (fall) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!dat_f_q) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    ST_DATA: begin
                        shreg_q   <= {dat_f_q, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_f_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign hist_shift = {hist_q, shreg_q};
    assign hist_d     = hist_shift[HW-1:0];

    assign ev_push      = frame_ok && (shreg_q != PS2_EXT) && (shreg_q != PS2_BRK);
    assign push_ev.ext  = ext_q;
    assign push_ev.brk  = brk_q;
    assign push_ev.code = shreg_q;

    // Prefix flags accumulate until a non-prefix byte consumes them.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            hist_q <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else if (frame_ok) begin
            hist_q <= hist_d;
            if (shreg_q == PS2_EXT) begin
                ext_q <= 1'b1;
            end else if (shreg_q == PS2_BRK) begin
                brk_q <= 1'b1;
            end else begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    assign ev_pop = rd_en && !fifo_empty;

    ps2_event_fifo #(
        .WIDTH (EVENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK_50),
        .rst_i   (reset),
        .push_i  (ev_push),
        .din_i   (push_ev),
        .pop_i   (ev_pop),
        .dout_o  (head_raw),
        .count_o (ev_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head = head_raw;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            overflow_q   <= (ev_push && fifo_full && !ev_pop)
                            || (overflow_q && !clr_flags);
            parity_err_q <= bad_par || (parity_err_q && !clr_flags);
            frame_err_q  <= bad_stop || timeout || (frame_err_q && !clr_flags);
        end
    end

    assign ev_valid   = !fifo_empty;
    assign ev_code    = head.code;
    assign ev_ext     = head.ext;
    assign ev_break   = head.brk;
    assign history    = hist_q;
    assign overflow   = overflow_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
